// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-RAM loader: state encoding and size defaults.
// No logic; referenced by the loader top and its byte/word assembler.
// No flow control of its own.
package loader_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 10;
    localparam int DEFAULT_MAX_WORDS  = 1024;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COUNT_HI = 3'd1,
        COUNT_LO = 3'd2,
        DATA     = 3'd3,
        WRITE    = 3'd4,
        DONE     = 3'd5,
        ERROR    = 3'd6
    } state_t;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs accepted bytes big-endian into 32-bit words using a shift register and 2-bit byte counter.
// Zero latency: word_next/word_complete are valid in the cycle the 4th byte is shifted in.
// No backpressure of its own; shifts only when the parent asserts shift_en.
module byte_word_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_next,
    output logic        word_complete
);

    // The first three bytes are held here; the fourth joins straight from the
    // input so the full word is available on the same edge it is accepted.
    logic [23:0] shift_reg;
    logic [1:0]  byte_count;

    assign word_next     = {shift_reg, byte_data};
    assign word_complete = shift_en && (byte_count == 2'd3);

    // Shift in accepted bytes; a reset or new load discards any partial word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg  <= '0;
            byte_count <= '0;
        end else if (clear) begin
            shift_reg  <= '0;
            byte_count <= '0;
        end else if (shift_en) begin
            shift_reg  <= word_next[23:0];
            byte_count <= byte_count + 2'd1;
        end
    end

endmodule

// File: rtl/instruction_ram_loader.sv
// Loads a length-prefixed byte stream into instruction RAM as big-endian 32-bit words.
// Write strobe is registered: enable/address/data appear the cycle after the 4th byte of a word.
// byte_ready drops in WRITE, DONE, ERROR and IDLE; an offered byte waits until DATA resumes.
module instruction_ram_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int MAX_WORDS  = DEFAULT_MAX_WORDS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] i_ram_writing_address,
    output logic [31:0]           i_ram_input,
    output logic                  flag_write_i_ram,
    output logic                  loading,
    output logic                  load_done,
    output logic                  load_error
);

    state_t                state;
    state_t                state_next;
    logic [7:0]            count_hi;
    logic [15:0]           word_count;
    logic [ADDR_WIDTH-1:0] word_index;
    logic [15:0]           header_count;
    logic [31:0]           word_next;
    logic                  word_complete;
    logic                  accept;
    logic                  start;
    logic                  header_bad;
    logic                  last_word;

    assign accept       = byte_valid && byte_ready;
    assign start        = load_start && ((state == IDLE) || (state == ERROR));
    assign header_count = {count_hi, byte_data};
    assign header_bad   = (header_count == 16'd0) ||
                          ({16'd0, header_count} > 32'(MAX_WORDS));
    assign last_word    = ({{(32-ADDR_WIDTH){1'b0}}, word_index} ==
                           ({16'd0, word_count} - 32'd1));

    byte_word_assembler u_assembler (
        .clock         (clock),
        .reset         (reset),
        .clear         (start),
        .shift_en      (accept && (state == DATA)),
        .byte_data     (byte_data),
        .word_next     (word_next),
        .word_complete (word_complete)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        loading    = 1'b0;
        load_done  = 1'b0;
        load_error = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = COUNT_HI;
            end
            COUNT_HI: begin
                byte_ready = 1'b1;
                loading    = 1'b1;
                if (accept) state_next = COUNT_LO;
            end
            COUNT_LO: begin
                byte_ready = 1'b1;
                loading    = 1'b1;
                if (accept) state_next = header_bad ? ERROR : DATA;
            end
            DATA: begin
                byte_ready = 1'b1;
                loading    = 1'b1;
                if (word_complete) state_next = WRITE;
            end
            WRITE: begin
                loading    = 1'b1;
                state_next = last_word ? DONE : DATA;
            end
            DONE: begin
                load_done  = 1'b1;
                state_next = IDLE;
            end
            ERROR: begin
                load_error = 1'b1;
                if (start) state_next = COUNT_HI;
            end
            default: state_next = IDLE;
        endcase
    end

    // Header capture, word index and the registered RAM write port; address
    // and data only change when a new word is written, otherwise they hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_hi              <= '0;
            word_count            <= '0;
            word_index            <= '0;
            flag_write_i_ram      <= 1'b0;
            i_ram_writing_address <= '0;
            i_ram_input           <= '0;
        end else begin
            flag_write_i_ram <= word_complete;
            if (start) begin
                count_hi   <= '0;
                word_count <= '0;
                word_index <= '0;
            end
            if (accept && (state == COUNT_HI)) count_hi <= byte_data;
            if (accept && (state == COUNT_LO)) word_count <= header_count;
            if ((state == WRITE) && !last_word) word_index <= word_index + ADDR_WIDTH'(1);
            if (word_complete) begin
                i_ram_writing_address <= word_index;
                i_ram_input           <= word_next;
            end
        end
    end

endmodule

// File: tb/tb_instruction_ram_loader.sv
// Directed bench for instruction_ram_loader with a write/done scoreboard.
// Drivers push expected writes before issuing bytes; a negedge monitor pops and compares.
// Bytes are offered with valid held until accepted, optionally gapped.
module tb_instruction_ram_loader;

    localparam int AW = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          load_start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready;
    logic [AW-1:0] i_ram_writing_address;
    logic [31:0]   i_ram_input;
    logic          flag_write_i_ram;
    logic          loading;
    logic          load_done;
    logic          load_error;

    instruction_ram_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(1024)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .load_start            (load_start),
        .byte_valid            (byte_valid),
        .byte_data             (byte_data),
        .byte_ready            (byte_ready),
        .i_ram_writing_address (i_ram_writing_address),
        .i_ram_input           (i_ram_input),
        .flag_write_i_ram      (flag_write_i_ram),
        .loading               (loading),
        .load_done             (load_done),
        .load_error            (load_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    int          checks = 0;
    int          fails = 0;
    wr_t         exp_q[$];
    int          exp_done = 0;
    logic [31:0] prog[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every write strobe and done pulse must match the scoreboard.
    always @(negedge clock) begin
        wr_t e;
        if (flag_write_i_ram === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write",
                         i_ram_writing_address, i_ram_input);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(i_ram_writing_address), 32'(e.addr));
                check("write_data", i_ram_input, e.data);
            end
        end
        if (load_done === 1'b1) begin
            checks++;
            if (exp_done == 0) begin
                fails++;
                $display("FAIL unexpected_done: got load_done=1, required 0");
            end else begin
                exp_done--;
            end
        end
    end

    // All driver tasks start and end just after a negedge.
    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clock);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit took;
        took = 1'b0;
        if (gap) begin
            byte_valid = 1'b0;
            @(negedge clock);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int n = 0; n < 50 && !took; n++) begin
            took = byte_ready;
            @(negedge clock);
        end
        if (!took) begin
            checks++;
            fails++;
            $display("FAIL byte_timeout: got byte_ready=0 for 50 cycles, required acceptance of %h", b);
        end
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 40 && !idle; n++) begin
            if (loading === 1'b0 && load_done === 1'b0) idle = 1'b1;
            else @(negedge clock);
        end
        check("idle_reached", {31'd0, idle}, 32'd1);
    endtask

    // Load every word in prog; optionally gap bytes and pulse load_start after data byte 'poke'.
    task automatic run_load(input bit gap, input int poke);
        int nb;
        for (int i = 0; i < prog.size(); i++) exp_q.push_back({AW'(i), prog[i]});
        exp_done++;
        pulse_start();
        send_byte(8'(prog.size() >> 8), gap);
        send_byte(8'(prog.size()), gap);
        nb = 0;
        for (int i = 0; i < prog.size(); i++) begin
            for (int k = 3; k >= 0; k--) begin
                send_byte(prog[i][k*8 +: 8], gap);
                if (nb == poke) begin
                    byte_valid = 1'b0;
                    pulse_start();
                end
                nb++;
            end
        end
        byte_valid = 1'b0;
        wait_idle();
        check("writes_drained", exp_q.size(), 0);
        check("done_seen", exp_done, 0);
    endtask

    task automatic bad_header(input logic [7:0] hi, input logic [7:0] lo);
        pulse_start();
        send_byte(hi, 1'b0);
        send_byte(lo, 1'b0);
        @(negedge clock);
        check("err_load_error", {31'd0, load_error}, 32'd1);
        check("err_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("err_loading", {31'd0, loading}, 32'd0);
        byte_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flag"}, {31'd0, flag_write_i_ram}, 32'd0);
        check({tag, "_addr"}, 32'(i_ram_writing_address), 32'd0);
        check({tag, "_data"}, i_ram_input, 32'd0);
        check({tag, "_loading"}, {31'd0, loading}, 32'd0);
        check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
        check({tag, "_done"}, {31'd0, load_done}, 32'd0);
        check({tag, "_error"}, {31'd0, load_error}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1000000, required end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        // Two-word load, valid held constant.
        prog = {32'h12345678, 32'h9ABCDEF0};
        run_load(1'b0, -1);
        check("hold_addr", 32'(i_ram_writing_address), 32'd1);
        check("hold_data", i_ram_input, 32'h9ABCDEF0);

        // Same program with gapped valid; bytes offered during WRITE wait for DATA.
        run_load(1'b1, -1);

        // Zero-length header is rejected; load_start from ERROR restarts cleanly.
        bad_header(8'h00, 8'h00);
        repeat (3) @(negedge clock);
        check("err_sticky", {31'd0, load_error}, 32'd1);
        pulse_start();
        check("err_cleared", {31'd0, load_error}, 32'd0);
        check("restart_loading", {31'd0, loading}, 32'd1);
        prog = {32'hCAFEF00D};
        run_load(1'b0, -1);

        // 1025 words is one too many; 1024 fills addresses 0..1023 without wrap.
        bad_header(8'h04, 8'h01);
        prog.delete();
        for (int i = 0; i < 1024; i++) prog.push_back(32'hA500_0000 + 32'(i));
        run_load(1'b0, -1);
        check("max_last_addr", 32'(i_ram_writing_address), 32'd1023);
        check("max_last_data", i_ram_input, 32'hA500_03FF);

        // load_start mid-DATA is ignored; the original count of two words stands.
        prog = {32'h11223344, 32'h55667788};
        run_load(1'b0, 1);

        // Reset two bytes into word 1: everything clears at once, no write to address 1.
        exp_q.push_back({AW'(0), 32'hDEADBEEF});
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clock);
        byte_valid = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_no_pending", exp_q.size(), 0);
        prog = {32'h0BADC0DE};
        run_load(1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/instruction_ram_loader.md
INSTRUCTION_RAM_LOADER -- requirements
Module: instruction_ram_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning the width of the instruction-RAM write address.
REQ-002 SHALL have parameter MAX_WORDS, default 1024, meaning the largest accepted program length in words.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load_start  input  1  one-cycle pulse that begins a program load.
REQ-006 SHALL have port byte_valid  input  1  byte_data holds a valid byte.
REQ-007 SHALL have port byte_data  input  8  incoming program byte.
REQ-008 SHALL have port byte_ready  output  1  loader accepts byte_data this cycle.
REQ-009 SHALL have port i_ram_writing_address  output  ADDR_WIDTH  instruction-RAM write address.
REQ-010 SHALL have port i_ram_input  output  32  instruction-RAM write data.
REQ-011 SHALL have port flag_write_i_ram  output  1  instruction-RAM write enable.
REQ-012 SHALL have port loading  output  1  high while a load is in progress.
REQ-013 SHALL have port load_done  output  1  one-cycle pulse on successful completion.
REQ-014 SHALL have port load_error  output  1  held high after a rejected header until the next load_start.

Function
REQ-015 SHALL implement states IDLE, COUNT_HI, COUNT_LO, DATA, WRITE, DONE and ERROR.
REQ-016 SHALL accept a byte only on a posedge where byte_valid and byte_ready are both high.
REQ-017 SHALL drive byte_ready high only in COUNT_HI, COUNT_LO and DATA.
REQ-018 SHALL move IDLE->COUNT_HI on load_start, clearing load_error, the word index and the byte counter.
REQ-019 SHALL ignore load_start outside IDLE and ERROR; in ERROR, load_start SHALL act as it does in IDLE.
REQ-020 SHALL take word count as a big-endian 16-bit header: COUNT_HI byte, then COUNT_LO byte.
REQ-021 SHALL, after COUNT_LO, go to ERROR when count is 0 or exceeds MAX_WORDS, and otherwise go to DATA.
REQ-022 SHALL assemble each word from 4 accepted bytes, big-endian (first byte into bits 31:24).
REQ-023 SHALL enter WRITE on the cycle after the 4th byte, where flag_write_i_ram=1 for exactly one clock, i_ram_writing_address=word index and i_ram_input=assembled word.
REQ-024 SHALL register address, data and enable on posedge so they are stable at the RAM negedge write.
REQ-025 SHALL, after WRITE, go to DONE when index == count-1, and otherwise increment the index and return to DATA.
REQ-026 SHALL pulse load_done for one cycle in DONE, then return to IDLE.
REQ-027 SHALL drive loading high in COUNT_HI, COUNT_LO, DATA and WRITE.
REQ-028 SHALL hold i_ram_writing_address and i_ram_input at their last values when not writing.
REQ-029 SHALL never write outside 0..count-1; the index SHALL not wrap within a load.

Reset
REQ-030 SHALL, on reset assertion at any time (including mid-word or mid-WRITE), immediately force IDLE and set every output, index, byte counter and the word register to 0.
REQ-031 SHALL discard a partial word on reset and issue no write for it.

Structure
REQ-032 SHALL place the state encoding and the MAX_WORDS/ADDR_WIDTH defaults in shared package loader_pkg.
REQ-033 SHALL use one sub-module, byte_word_assembler (4-byte shift register plus 2-bit byte counter, word_complete strobe).

Verification
REQ-034 Reset, then load_start, then bytes 00 02 | 12 34 56 78 | 9A BC DE F0 with byte_valid constant -> writes 0x12345678@0 and 0x9ABCDEF0@1, each with a 1-cycle enable, then one load_done pulse, then IDLE.
REQ-035 Header 00 00 -> ERROR, load_error=1, no write, byte_ready=0; a subsequent load_start clears load_error.
REQ-036 Header 04 01 (1025) -> ERROR; header 04 00 with 1024 words -> last write at address 1023, no wrap.
REQ-037 byte_valid gapped every other cycle and held during WRITE -> identical words/addresses; the byte presented during WRITE is not consumed until DATA.
REQ-038 Reset asserted after the 2nd byte of word 1 -> all outputs 0 asynchronously, no write to address 1; a fresh load succeeds.
REQ-039 load_start pulsed mid-DATA -> ignored; load completes with the original count.
